// File: rtl/maxbw_burst_sequencer.sv
// Capture-burst controller for the max-bandwidth ingress path: hunts a sync word,
// XOR-folds the following words into a signature, and drains it bytewise with valid/ready.
module maxbw_burst_sequencer #(
  parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A,
  parameter int          LEN_W     = 8,
  parameter int          HUNT_TMO  = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_lo,
  input  logic [15:0]      in_hi,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TMR_W = $clog2(HUNT_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      word;
  logic [31:0]      acc;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       idx;
  logic             done_q, err_q;
  logic             load, fold, byte_acc, done_set, err_set;

  // Sample flops sit upstream; both halves are already aligned to posedge here.
  assign word = {in_hi, in_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fold      = 1'b0;
    byte_acc  = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            load      = 1'b1;
            state_nxt = S_HUNT;
          end
        end
        S_HUNT: begin
          if (word == SYNC_WORD) begin
            state_nxt = S_CAPTURE;
          end else if (tmr == TMR_W'(HUNT_TMO - 1)) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_CAPTURE: begin
          fold = 1'b1;
          // cnt counts words already folded, so this is the fold of word number len
          if (cnt == len_q - LEN_W'(1)) begin
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            byte_acc = 1'b1;
            if (idx == 2'd3) begin
              done_set  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      len_q  <= '0;
      cnt    <= '0;
      tmr    <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_set;
      err_q  <= err_set;
      if (load) begin
        len_q <= len;
        acc   <= '0;
        cnt   <= '0;
        idx   <= '0;
      end
      if (fold) begin
        acc <= acc ^ word;
        cnt <= cnt + LEN_W'(1);
      end
      if (byte_acc) begin
        idx <= idx + 2'd1;
      end
      // Timer only runs while hunting, so every HUNT entry starts from zero
      if (state == S_HUNT) begin
        tmr <= tmr + TMR_W'(1);
      end else begin
        tmr <= '0;
      end
    end
  end

  always_comb begin
    out_byte = 8'h00;
    if (state == S_DRAIN) begin
      case (idx)
        2'd0:    out_byte = acc[31:24];
        2'd1:    out_byte = acc[23:16];
        2'd2:    out_byte = acc[15:8];
        default: out_byte = acc[7:0];
      endcase
    end
  end

  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_maxbw_burst_sequencer.sv
// Directed bench for maxbw_burst_sequencer: burst signature, stalls, timeout, abort, reset.
module tb_maxbw_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_lo, in_hi;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;

  maxbw_burst_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] w);
    in_hi = w[31:16];
    in_lo = w[15:0];
  endtask

  // Leaves the DUT in CAPTURE (start, then sync word one cycle later)
  task automatic begin_burst(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    set_word(32'hA5A5_5A5A);
    tick();
  endtask

  task automatic feed(input logic [31:0] w);
    set_word(w);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0; out_ready = 1'b1;
    set_word(32'h0);
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (out_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h expected 00", out_byte); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b expected 00", {done, err}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4];
    exp_b = '{8'hED, 8'hCB, 8'h56, 8'h78};
    out_ready = 1'b1;
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
    set_word(32'hA5A5_5A5A); tick();
    feed(32'h1234_5678);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    feed(32'hFFFF_0000);
    set_word(32'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_byte !== exp_b[i] || done !== 1'b0) begin
        bad++; $display("FAIL basic_byte%0d: got v=%b b=%h d=%b expected v=1 b=%h d=0", i, out_valid, out_byte, done, exp_b[i]);
      end
      tick();
    end
    total++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done: got d=%b v=%b busy=%b expected 1 0 0", done, out_valid, busy);
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [4];
    exp_b = '{8'hED, 8'hCB, 8'h56, 8'h78};
    out_ready = 1'b1;
    begin_burst(8'd2);
    feed(32'h1234_5678);
    feed(32'hFFFF_0000);
    set_word(32'h0);
    for (int i = 0; i < 2; i++) begin
      total++; if (out_byte !== exp_b[i]) begin bad++; $display("FAIL stall_byte%0d: got %h expected %h", i, out_byte, exp_b[i]); end
      tick();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (out_valid !== 1'b1 || out_byte !== 8'h56) begin
        bad++; $display("FAIL stall_hold%0d: got v=%b b=%h expected v=1 b=56", c, out_valid, out_byte);
      end
      tick();
    end
    out_ready = 1'b1;
    total++; if (out_byte !== 8'h56) begin bad++; $display("FAIL stall_release: got %h expected 56", out_byte); end
    tick();
    total++; if (out_byte !== 8'h78 || done !== 1'b0) begin
      bad++; $display("FAIL stall_last: got b=%h d=%b expected b=78 d=0", out_byte, done);
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_hunt_timeout();
    int  n = 0;
    bit  seen_valid = 0;
    bit  got_err = 0;
    set_word(32'h0000_0000);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (out_valid) seen_valid = 1;
      if (err) begin n = k; got_err = 1; break; end
    end
    total++; if (!got_err || n != 1023) begin bad++; $display("FAIL hunt_err_cycle: got %0d expected 1023", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hunt_idle: got busy=%b expected 0", busy); end
    total++; if (seen_valid) begin bad++; $display("FAIL hunt_valid: got 1 expected 0"); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL hunt_err_pulse: got %b expected 0", err); end
  endtask

  task automatic test_abort();
    logic [7:0] exp_b [4];
    exp_b = '{8'h00, 8'h00, 8'h11, 8'h11};
    out_ready = 1'b1;
    begin_burst(8'd4);
    feed(32'hDEAD_BEEF);
    abort = 1'b1;
    feed(32'h0BAD_F00D);
    abort = 1'b0;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL abort_pulses: got %b expected 00", {done, err}); end
    begin_burst(8'd1);
    feed(32'h0000_1111);
    set_word(32'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
        bad++; $display("FAIL abort_fresh%0d: got v=%b b=%h expected v=1 b=%h", i, out_valid, out_byte, exp_b[i]);
      end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_fresh_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_ignored_start();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA5, 8'hA5, 8'h5A, 8'hA5};
    start = 1'b1; len = 8'd0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b expected 0", busy); end
    start = 1'b1; len = 8'd3; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL start_abort: got busy=%b d=%b expected 0 0", busy, done);
    end
    // start held with a different len during CAPTURE; the sync pattern is data there
    begin_burst(8'd2);
    start = 1'b1; len = 8'd1;
    feed(32'hA5A5_5A5A);
    feed(32'h0000_00FF);
    start = 1'b0;
    set_word(32'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
        bad++; $display("FAIL busy_start%0d: got v=%b b=%h expected v=1 b=%h", i, out_valid, out_byte, exp_b[i]);
      end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_start_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    begin_burst(8'd2);
    feed(32'h1234_5678);
    feed(32'hFFFF_0000);
    set_word(32'h0);
    tick();
    total++; if (out_byte !== 8'hCB) begin bad++; $display("FAIL rst_pre: got %h expected CB", out_byte); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00) begin
      bad++; $display("FAIL rst_mid: got v=%b busy=%b b=%h expected 0 0 00", out_valid, busy, out_byte);
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_no_done: got %b expected 0", done); end
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_after: got busy=%b d=%b expected 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hunt_timeout();
    test_abort();
    test_ignored_start();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
